// File: rtl/traffic_pkg.sv
// Shared light codes, phase enum and light-vector decode for the traffic timer.
// Used by traffic_phase_timer and its bench; no ports.
package traffic_pkg;

   localparam logic [1:0] LIGHT_GREEN  = 2'b01;
   localparam logic [1:0] LIGHT_YELLOW = 2'b10;
   localparam logic [1:0] LIGHT_RED    = 2'b11;

   typedef enum logic [1:0] {
      PH_RED,
      PH_GREEN,
      PH_YELLOW
   } phase_t;

   // Green beats yellow beats red; code 00 falls through to red.
   function automatic phase_t decode_phase(input logic [7:0] v);
      logic g;
      logic y;
      g = 1'b0;
      y = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (v[2*i +: 2] == LIGHT_GREEN)  g = 1'b1;
         if (v[2*i +: 2] == LIGHT_YELLOW) y = 1'b1;
      end
      if (g)      return PH_GREEN;
      else if (y) return PH_YELLOW;
      else        return PH_RED;
   endfunction

   // Conflicting movements (two or more fields not red) or a dark field.
   function automatic logic illegal_pattern(input logic [7:0] v);
      int  n;
      logic dark;
      n    = 0;
      dark = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (v[2*i +: 2] != LIGHT_RED) n++;
         if (v[2*i +: 2] == 2'b00)     dark = 1'b1;
      end
      return (n > 1) || dark;
   endfunction

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Light buses from the controller and expiry flags back to it.
// master = controller (drives lights), slave = timer (drives flags).
interface traffic_phase_timer_if;

   logic [1:0] S1_S3;
   logic [1:0] S2_S4;
   logic [1:0] S1T_S3T;
   logic [1:0] S2T_S4T;
   logic       tGreen;
   logic       tYellow;
   logic       tRed;
   logic       fault;

   modport master (
      output S1_S3, S2_S4, S1T_S3T, S2T_S4T,
      input  tGreen, tYellow, tRed, fault
   );

   modport slave (
      input  S1_S3, S2_S4, S1T_S3T, S2T_S4T,
      output tGreen, tYellow, tRed, fault
   );

endinterface

// File: rtl/traffic_tick_gen.sv
// CLK_DIV prescaler: one-cycle tick every CLK_DIV clocks, restarted by clr.
// Ports: clock, reset (sync, high), clr (sync restart), tick (out).
module traffic_tick_gen #(
   parameter int CLK_DIV = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] pre;
   logic          wrap;

   assign wrap = (pre == PW'(CLK_DIV - 1));
   assign tick = wrap;

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         pre <= '0;
      end else if (wrap) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_phase_timer.sv
// Times how long the current light pattern is held; raises tGreen/tYellow/tRed.
// Ports: clock, reset (sync, high), bus (slave: lights in, flags + fault out).
// Option: TRAFFIC_TIMER_FAULT_DETECT_EN enables sticky illegal-pattern fault.
module traffic_phase_timer
   import traffic_pkg::*;
#(
   parameter int CLK_DIV      = 1000,
   parameter int CNT_W        = 8,
   parameter int GREEN_TICKS  = 30,
   parameter int YELLOW_TICKS = 4,
   parameter int RED_TICKS    = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   traffic_phase_timer_if.slave bus
);

   logic [7:0]       v;
   logic [7:0]       prev;
   logic             change;
   logic             tick;
   logic             kill;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] dur;
   phase_t           ph;
   logic             tg;
   logic             ty;
   logic             tr;

   assign v      = {bus.S1_S3, bus.S2_S4, bus.S1T_S3T, bus.S2T_S4T};
   assign change = (v != prev);
   // prev equals v whenever timing runs, so its phase is the live one.
   assign ph     = decode_phase(prev);

   always_comb begin
      dur = CNT_W'(RED_TICKS);
      case (ph)
         PH_GREEN:  dur = CNT_W'(GREEN_TICKS);
         PH_YELLOW: dur = CNT_W'(YELLOW_TICKS);
         default:   dur = CNT_W'(RED_TICKS);
      endcase
   end

   traffic_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clock (clock),
      .reset (reset),
      .clr   (change),
      .tick  (tick)
   );

`ifdef TRAFFIC_TIMER_FAULT_DETECT_EN
   logic fault_q;
   logic fault_set;

   assign fault_set = illegal_pattern(v);
   assign kill      = fault_q | fault_set;
   assign bus.fault = fault_q;

   always_ff @(posedge clock) begin
      if (reset) fault_q <= 1'b0;
      else       fault_q <= fault_q | fault_set;
   end
`else
   assign kill      = 1'b0;
   assign bus.fault = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         prev <= 8'hFF;
         cnt  <= '0;
         tg   <= 1'b0;
         ty   <= 1'b0;
         tr   <= 1'b0;
      end else if (change) begin
         prev <= v;
         cnt  <= '0;
         tg   <= 1'b0;
         ty   <= 1'b0;
         tr   <= 1'b0;
      end else begin
         // Saturate at dur; the flag for this phase sets on the last tick.
         if (tick && cnt < dur) begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == dur) begin
               tg <= (ph == PH_GREEN);
               ty <= (ph == PH_YELLOW);
               tr <= (ph == PH_RED);
            end
         end
         // A fault freezes the controller by holding all expiries low.
         if (kill) begin
            tg <= 1'b0;
            ty <= 1'b0;
            tr <= 1'b0;
         end
      end
   end

   assign bus.tGreen  = tg;
   assign bus.tYellow = ty;
   assign bus.tRed    = tr;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Scoreboard bench for traffic_phase_timer with CLK_DIV=4, G=5, Y=2, R=3.
// Expected expiry latencies are queued at stimulus, compared on output rise.
module tb_traffic_phase_timer;
   import traffic_pkg::*;

   localparam int DIV = 4;
   localparam int GT  = 5;
   localparam int YT  = 2;
   localparam int RT  = 3;

   logic clock;
   logic reset;

   traffic_phase_timer_if bus ();

   traffic_phase_timer #(
      .CLK_DIV      (DIV),
      .CNT_W        (8),
      .GREEN_TICKS  (GT),
      .YELLOW_TICKS (YT),
      .RED_TICKS    (RT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string tag;
      int    lat;
   } exp_t;

   exp_t sb[$];
   int   n_tot;
   int   n_bad;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic set_v(input logic [7:0] v);
      bus.S1_S3   = v[7:6];
      bus.S2_S4   = v[5:4];
      bus.S1T_S3T = v[3:2];
      bus.S2T_S4T = v[1:0];
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   function automatic logic [2:0] outs();
      return {bus.tRed, bus.tYellow, bus.tGreen};
   endfunction

   // sel: 0 green, 1 yellow, 2 red. start is the edge index already reached.
   task automatic expect_rise(input string tag, input int sel,
                              input int start, input int cyc);
      int         lat;
      bit         other;
      bit         hit;
      logic [2:0] o;
      exp_t       e;
      sb.push_back('{tag, cyc});
      lat   = start;
      other = 1'b0;
      hit   = 1'b0;
      for (int i = 0; i < cyc - start + 10 && !hit; i++) begin
         @(posedge clock);
         lat++;
         #1;
         o = outs();
         if ((o & ~(3'b001 << sel)) != 3'b000) other = 1'b1;
         if (o[sel]) hit = 1'b1;
      end
      if (!hit) lat = -1;
      e = sb.pop_front();
      chk(e.tag, lat, e.lat);
      chk({tag, "_excl"}, {31'd0, other}, 0);
   endtask

   initial begin
      n_tot = 0;
      n_bad = 0;
      reset = 1'b1;
      set_v(8'hFF);
      step(3);
      chk("rst_outs", {28'd0, bus.fault, outs()}, 0);
      reset = 1'b0;
      expect_rise("red_rst", 2, 0, RT * DIV);
      step(5);
      chk("red_hold", {31'd0, bus.tRed}, 1);

      set_v(8'h7F);
      step(1);
      chk("red_drop", {31'd0, bus.tRed}, 0);
      expect_rise("green", 0, 0, GT * DIV);

      set_v(8'hDF);
      step(10);
      chk("g_abort_low", {31'd0, bus.tGreen}, 0);
      set_v(8'hEF);
      expect_rise("yellow", 1, -1, YT * DIV);

      set_v(8'h7F);
      step(15);
      chk("g_sw_low", {31'd0, bus.tGreen}, 0);
      set_v(8'hDF);
      expect_rise("green_sw", 0, 14, 15 + GT * DIV);

      set_v(8'h7F);
      step(15);
      reset = 1'b1;
      step(1);
      chk("midrst_outs", {29'd0, outs()}, 0);
      step(1);
      reset = 1'b0;
      expect_rise("green_rst", 0, -1, GT * DIV);

      set_v(8'hDF);
      step(1);
      set_v(8'h7F);
      step(1);
      chk("glitch_low", {29'd0, outs()}, 0);
      expect_rise("glitch", 0, 0, GT * DIV);

      set_v(8'h5F);
      step(1);
      chk("bad_outs", {29'd0, outs()}, 0);
`ifdef TRAFFIC_TIMER_FAULT_DETECT_EN
      chk("fault_set", {31'd0, bus.fault}, 1);
      step(25);
      chk("fault_frz", {29'd0, outs()}, 0);
      set_v(8'hFF);
      step(20);
      chk("fault_stky", {31'd0, bus.fault}, 1);
      chk("fault_red", {31'd0, bus.tRed}, 0);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("fault_clr", {31'd0, bus.fault}, 0);
      expect_rise("red_postf", 2, 0, RT * DIV);
`else
      chk("fault_off", {31'd0, bus.fault}, 0);
      expect_rise("green_nof", 0, 0, GT * DIV);
      chk("fault_off2", {31'd0, bus.fault}, 0);
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
